// File: rtl/decoder_pkg.sv
// decoder_pkg: shared types and the reference decode rule for selector decoders.
// Contents: occupancy state enum, decode mode enum, dp_decode() returning {err, q}.
// dp_decode works on fixed maximum widths; callers zero-extend sel and slice q.
package decoder_pkg;

   typedef enum logic [1:0] {DP_EMPTY, DP_ONE, DP_TWO} dp_state_t;
   typedef enum logic {DP_ONEHOT, DP_THERM} dp_mode_t;

   // Largest decoder any caller may build; result is DP_MAX_OUT q bits plus err on top.
   localparam int unsigned DP_MAX_OUT = 256;
   localparam int unsigned DP_MAX_SEL = 16;

   // Returns {err, q}. Only the low 'outputs' bits of q are meaningful; the rest stay 0.
   // sel is compared as a 32-bit unsigned value, wide enough that out-of-range
   // selectors can never alias onto a valid index.
   function automatic logic [DP_MAX_OUT:0] dp_decode(
      input logic [DP_MAX_SEL-1:0] sel,
      input dp_mode_t              mode,
      input int unsigned           outputs
   );
      logic [DP_MAX_OUT:0] r;
      int unsigned         s;
      r = '0;
      s = 32'(sel);
      if (s >= outputs) begin
         r[DP_MAX_OUT] = 1'b1;
      end else begin
         for (int unsigned i = 0; i < DP_MAX_OUT; i++) begin
            if (i < outputs) begin
               r[i] = (mode == DP_THERM) ? (i <= s) : (i == s);
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/decoder_core.sv
// decoder_core: purely combinational selector decoder (one-hot or thermometer).
// Ports: sel_i selector, mode_i decode mode, q_o decoded vector, err_o selector >= OUTPUTS.
// Out-of-range selectors give q_o = 0 and err_o = 1 in either mode.
module decoder_core
   import decoder_pkg::*;
#(
   parameter  int unsigned OUTPUTS  = 8,
   localparam int unsigned SEL_BITS = $clog2(OUTPUTS)
) (
   input  logic [SEL_BITS-1:0] sel_i,
   input  dp_mode_t            mode_i,
   output logic [OUTPUTS-1:0]  q_o,
   output logic                err_o
);

   logic [DP_MAX_SEL-1:0] sel_ext;
   logic [DP_MAX_OUT:0]   dec_full;
   logic                  dec_unused;

   always_comb begin
      sel_ext                = '0;
      sel_ext[SEL_BITS-1:0]  = sel_i;
   end

   assign dec_full = dp_decode(sel_ext, mode_i, OUTPUTS);
   assign q_o      = dec_full[OUTPUTS-1:0];
   assign err_o    = dec_full[DP_MAX_OUT];

   // q bits above OUTPUTS are always zero by construction of dp_decode.
   assign dec_unused = ^dec_full[DP_MAX_OUT-1:OUTPUTS];

endmodule

// File: rtl/decoder_pipe.sv
// decoder_pipe: flow-controlled selector decoder with a 2-entry skid buffer.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_sel/in_mode accept side;
//        out_valid/out_ready/out_q/out_err produce side; err_cnt only with DECODER_PIPE_ERR_CNT_EN.
// Latency 1 cycle when empty; in_ready is registered and never combinational on out_ready.
module decoder_pipe
   import decoder_pkg::*;
#(
   parameter  int unsigned OUTPUTS   = 8,
   parameter  int unsigned ERR_CNT_W = 8,
   localparam int unsigned SEL_BITS  = $clog2(OUTPUTS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SEL_BITS-1:0]  in_sel,
   input  logic                 in_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUTPUTS-1:0]   out_q,
   output logic                 out_err
`ifdef DECODER_PIPE_ERR_CNT_EN
   ,
   output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

   // Stored entries are {err, q}.
   dp_state_t            state_q, state_d;
   logic [OUTPUTS:0]     main_q, main_d;
   logic [OUTPUTS:0]     skid_q, skid_d;
   logic                 in_ready_q;
   logic [OUTPUTS-1:0]   dec_q;
   logic                 dec_err;
   logic                 in_xfer;
   logic                 out_xfer;

   decoder_core #(
      .OUTPUTS (OUTPUTS)
   ) u_core (
      .sel_i  (in_sel),
      .mode_i (dp_mode_t'(in_mode)),
      .q_o    (dec_q),
      .err_o  (dec_err)
   );

   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = out_valid & out_ready;
   assign out_valid = (state_q != DP_EMPTY);
   assign out_q     = main_q[OUTPUTS-1:0];
   assign out_err   = main_q[OUTPUTS];
   assign in_ready  = in_ready_q;

   // Decoded data is only captured on in_xfer, so an undriven in_sel while
   // in_valid is low never reaches the registers.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      unique case (state_q)
         DP_EMPTY: begin
            if (in_xfer) begin
               state_d = DP_ONE;
               main_d  = {dec_err, dec_q};
            end
         end
         DP_ONE: begin
            if (in_xfer && !out_xfer) begin
               state_d = DP_TWO;
               skid_d  = {dec_err, dec_q};
            end else if (in_xfer && out_xfer) begin
               main_d  = {dec_err, dec_q};
            end else if (out_xfer) begin
               state_d = DP_EMPTY;
            end
         end
         DP_TWO: begin
            // in_ready is low here, so only the drain case exists.
            if (out_xfer) begin
               state_d = DP_ONE;
               main_d  = skid_q;
            end
         end
         default: begin
            state_d = DP_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= DP_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         // Registered look-ahead: ready next cycle unless both slots will be full.
         in_ready_q <= (state_d != DP_TWO);
      end
   end

`ifdef DECODER_PIPE_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (in_xfer && dec_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   localparam int unsigned ERR_CNT_W_UNUSED = ERR_CNT_W;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// tb_decoder_pipe: directed table vectors, backpressure and reset sequences, and a
// randomized valid/ready scoreboard run against an 8-output and a 6-output instance.
module tb_decoder_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   // 8-output instance
   logic       in_valid, in_ready, in_mode, out_valid, out_ready, out_err;
   logic [2:0] in_sel;
   logic [7:0] out_q;
   // 6-output instance
   logic       in_valid6, in_ready6, in_mode6, out_valid6, out_ready6, out_err6;
   logic [2:0] in_sel6;
   logic [5:0] out_q6;
`ifdef DECODER_PIPE_ERR_CNT_EN
   logic [7:0] err_cnt8;
   logic [1:0] err_cnt6;
`endif

   decoder_pipe #(.OUTPUTS(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_err(out_err)
`ifdef DECODER_PIPE_ERR_CNT_EN
      , .err_cnt(err_cnt8)
`endif
   );

   decoder_pipe #(.OUTPUTS(6), .ERR_CNT_W(2)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid6), .in_ready(in_ready6), .in_sel(in_sel6), .in_mode(in_mode6),
      .out_valid(out_valid6), .out_ready(out_ready6), .out_q(out_q6), .out_err(out_err6)
`ifdef DECODER_PIPE_ERR_CNT_EN
      , .err_cnt(err_cnt6)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0] sel;
      logic       mode;
      logic [7:0] q;
      logic       err;
      logic [1:0] cnt;   // expected saturating err_cnt (6-output instance, 2-bit)
   } vec_t;

   localparam int N8 = 12;
   localparam int N6 = 7;
   vec_t tab8[N8];
   vec_t tab6[N6];

   // Independent reference for the 8-output instance: {err, q}.
   function automatic logic [8:0] ref8(input logic [2:0] sel, input logic mode);
      logic [7:0] one;
      one = 8'h01 << sel;
      return mode ? {1'b0, (one << 1) - 8'h01} : {1'b0, one};
   endfunction

   logic [8:0] sb[$];
   logic [8:0] exp_w;
   logic [8:0] held_w;
   logic       held_vld;
   logic       acc_last;
   logic       rdy_probe;
   int         sent, got, cyc;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab8[0]  = '{3'd0, 1'b0, 8'h01, 1'b0, 2'd0};
      tab8[1]  = '{3'd1, 1'b0, 8'h02, 1'b0, 2'd0};
      tab8[2]  = '{3'd2, 1'b0, 8'h04, 1'b0, 2'd0};
      tab8[3]  = '{3'd3, 1'b0, 8'h08, 1'b0, 2'd0};
      tab8[4]  = '{3'd4, 1'b0, 8'h10, 1'b0, 2'd0};
      tab8[5]  = '{3'd5, 1'b0, 8'h20, 1'b0, 2'd0};
      tab8[6]  = '{3'd6, 1'b0, 8'h40, 1'b0, 2'd0};
      tab8[7]  = '{3'd7, 1'b0, 8'h80, 1'b0, 2'd0};
      tab8[8]  = '{3'd3, 1'b1, 8'h0F, 1'b0, 2'd0};
      tab8[9]  = '{3'd7, 1'b1, 8'hFF, 1'b0, 2'd0};
      tab8[10] = '{3'd0, 1'b1, 8'h01, 1'b0, 2'd0};
      tab8[11] = '{3'd5, 1'b1, 8'h3F, 1'b0, 2'd0};

      tab6[0]  = '{3'd6, 1'b0, 8'h00, 1'b1, 2'd1};
      tab6[1]  = '{3'd7, 1'b0, 8'h00, 1'b1, 2'd2};
      tab6[2]  = '{3'd6, 1'b1, 8'h00, 1'b1, 2'd3};
      tab6[3]  = '{3'd7, 1'b1, 8'h00, 1'b1, 2'd3};
      tab6[4]  = '{3'd5, 1'b1, 8'h3F, 1'b0, 2'd3};
      tab6[5]  = '{3'd5, 1'b0, 8'h20, 1'b0, 2'd3};
      tab6[6]  = '{3'd7, 1'b0, 8'h00, 1'b1, 2'd3};

      rst_n = 1'b0;
      in_valid = 0; in_sel = 0; in_mode = 0; out_ready = 0;
      in_valid6 = 0; in_sel6 = 0; in_mode6 = 0; out_ready6 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.out_valid", out_valid, 0);
      check("rst.out_q", out_q, 0);
      check("rst.out_err", out_err, 0);
      check("rst.in_ready", in_ready, 1);
`ifdef DECODER_PIPE_ERR_CNT_EN
      check("rst.err_cnt", err_cnt8, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Back-to-back one-hot sweep and thermometer vectors.
      out_ready = 1;
      @(posedge clk); #1;
      in_valid = 1; in_sel = tab8[0].sel; in_mode = tab8[0].mode;
      for (int i = 0; i < N8; i++) begin
         @(posedge clk); #1;
         check($sformatf("tab8[%0d].valid", i), out_valid, 1);
         check($sformatf("tab8[%0d].q", i), out_q, tab8[i].q);
         check($sformatf("tab8[%0d].err", i), out_err, tab8[i].err);
         check($sformatf("tab8[%0d].in_ready", i), in_ready, 1);
         if (i + 1 < N8) begin
            in_sel = tab8[i+1].sel; in_mode = tab8[i+1].mode;
         end else begin
            in_valid = 0;
         end
      end
      @(posedge clk); #1;
      check("tab8.drained", out_valid, 0);

      // Out-of-range selectors on the 6-output instance.
      out_ready6 = 1;
      in_valid6 = 1; in_sel6 = tab6[0].sel; in_mode6 = tab6[0].mode;
      for (int i = 0; i < N6; i++) begin
         @(posedge clk); #1;
         check($sformatf("tab6[%0d].valid", i), out_valid6, 1);
         check($sformatf("tab6[%0d].q", i), {2'b00, out_q6}, tab6[i].q);
         check($sformatf("tab6[%0d].err", i), out_err6, tab6[i].err);
`ifdef DECODER_PIPE_ERR_CNT_EN
         check($sformatf("tab6[%0d].err_cnt", i), err_cnt6, tab6[i].cnt);
`endif
         if (i + 1 < N6) begin
            in_sel6 = tab6[i+1].sel; in_mode6 = tab6[i+1].mode;
         end else begin
            in_valid6 = 0;
         end
      end

      // Backpressure: fill both slots, hold, then drain in order.
      out_ready = 0;
      in_valid = 1; in_sel = 3'd1; in_mode = 0;
      @(posedge clk); #1;
      check("bp.first_valid", out_valid, 1);
      check("bp.first_q", out_q, 8'h02);
      check("bp.ready_one", in_ready, 1);
      in_sel = 3'd2;
      @(posedge clk); #1;
      check("bp.ready_full", in_ready, 0);
      check("bp.hold_q0", out_q, 8'h02);
      in_sel = 3'd3;
      @(posedge clk); #1;
      check("bp.ready_still_full", in_ready, 0);
      check("bp.hold_q1", out_q, 8'h02);
      check("bp.hold_valid", out_valid, 1);
      out_ready = 1;
      @(posedge clk); #1;
      check("bp.drain_q1", out_q, 8'h04);
      check("bp.drain_ready", in_ready, 1);
      @(posedge clk); #1;
      check("bp.drain_q2", out_q, 8'h08);
      check("bp.drain_valid2", out_valid, 1);
      in_valid = 0;
      @(posedge clk); #1;
      check("bp.empty", out_valid, 0);

      // Reset while both slots are occupied.
      out_ready = 0;
      in_valid = 1; in_sel = 3'd5; in_mode = 1;
      @(posedge clk); #1;
      in_sel = 3'd6;
      @(posedge clk); #1;
      in_valid = 0;
      check("rm.full_ready", in_ready, 0);
      check("rm.full_q", out_q, 8'h3F);
      #2 rst_n = 1'b0;
      #1;
      check("rm.async_valid", out_valid, 0);
      check("rm.async_ready", in_ready, 1);
      @(posedge clk); #1;
      check("rm.valid", out_valid, 0);
      check("rm.q", out_q, 0);
      check("rm.err", out_err, 0);
      check("rm.ready", in_ready, 1);
`ifdef DECODER_PIPE_ERR_CNT_EN
      check("rm.err_cnt6", err_cnt6, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      in_valid = 1; in_sel = 3'd4; in_mode = 0; out_ready = 1;
      @(posedge clk); #1;
      check("rm.first_accept_valid", out_valid, 1);
      check("rm.first_accept_q", out_q, 8'h10);
      in_valid = 0;
      @(posedge clk); #1;
      check("rm.skid_discarded", out_valid, 0);

      // Random valid/ready traffic with an in-order scoreboard.
      sent = 0; got = 0; cyc = 0;
      held_vld = 0; acc_last = 0;
      in_valid = 0; out_ready = 0;
      while (got < 10000 && cyc < 60000) begin
         @(posedge clk); #1;
         cyc++;
         if (!(in_valid && !acc_last)) begin
            in_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            in_sel   = 3'($urandom_range(0, 7));
            in_mode  = 1'($urandom_range(0, 1));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         rdy_probe = in_ready;
         out_ready = ~out_ready;
         #1;
         if (in_ready !== rdy_probe) begin
            check("rnd.in_ready_comb", in_ready, rdy_probe);
         end
         out_ready = ~out_ready;
         #1;
         if (held_vld) begin
            check("rnd.stable", {out_err, out_q}, held_w);
         end
         held_vld = out_valid && !out_ready;
         held_w   = {out_err, out_q};
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("rnd.unexpected_out", 1, 0);
            end else begin
               exp_w = sb.pop_front();
               check("rnd.word", {out_err, out_q}, exp_w);
            end
            got++;
         end
         acc_last = in_valid && in_ready;
         if (acc_last) begin
            sb.push_back(ref8(in_sel, in_mode));
            sent++;
         end
      end
      check("rnd.count", got, 10000);
      check("rnd.sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
